// File: rtl/mp3_pkg.sv
// Shared types and constants for the MPEG-1 Layer III byte-stream front end.
// Holds parser states, header field positions and the frame-length table.
package mp3_pkg;

    localparam int MAX_FRAME_BYTES = 1441;

    typedef logic [$clog2(MAX_FRAME_BYTES)-1:0] len_t;

    typedef enum logic [2:0] {
        HUNT,
        SYNC2,
        HDR3,
        HDR4,
        CRC,
        SIDE,
        MAIN,
        EXPECT
    } state_t;

    localparam int HDR_LEN         = 4;
    localparam int CRC_LEN         = 2;
    localparam int SIDE_LEN_STEREO = 32;
    localparam int SIDE_LEN_MONO   = 17;

    // Header byte positions within the frame
    localparam int POS_SYNC1 = 0;
    localparam int POS_SYNC2 = 1;
    localparam int POS_RATE  = 2;
    localparam int POS_MODE  = 3;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;
    localparam logic [6:0] SYNC2_PAT = 7'b1111101;
    localparam logic [1:0] MODE_MONO = 2'd3;

    // floor(144000 * kbps / fs) for padding = 0; columns are 44.1k, 48k, 32k
    localparam len_t FRAME_LEN_ROM [1:14][0:2] = '{
        '{11'd104,  11'd96,  11'd144},
        '{11'd130,  11'd120, 11'd180},
        '{11'd156,  11'd144, 11'd216},
        '{11'd182,  11'd168, 11'd252},
        '{11'd208,  11'd192, 11'd288},
        '{11'd261,  11'd240, 11'd360},
        '{11'd313,  11'd288, 11'd432},
        '{11'd365,  11'd336, 11'd504},
        '{11'd417,  11'd384, 11'd576},
        '{11'd522,  11'd480, 11'd720},
        '{11'd626,  11'd576, 11'd864},
        '{11'd731,  11'd672, 11'd1008},
        '{11'd835,  11'd768, 11'd1152},
        '{11'd1044, 11'd960, 11'd1440}
    };

endpackage

// File: rtl/mp3_frame_len_rom.sv
// Combinational frame-length lookup from bitrate/sampling indices plus padding.
// Unused table codes (free format, bad, reserved rate) return zero.
module mp3_frame_len_rom
    import mp3_pkg::*;
(
    input  logic [3:0] bitrate_index,
    input  logic [1:0] sampling_freq,
    input  logic       padding,
    output len_t       frame_len
);

    always_comb begin
        frame_len = '0;
        if (bitrate_index != 4'd0 && bitrate_index != 4'd15 &&
            sampling_freq != 2'd3) begin
            frame_len = FRAME_LEN_ROM[bitrate_index][sampling_freq] +
                        len_t'(padding);
        end
    end

endmodule

// File: rtl/mp3_frame_parser.sv
// MP3 frame sync hunter and header parser; splits each frame into
// side-info bytes and main-data bytes with one cycle of latency.
module mp3_frame_parser
    import mp3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] axiid,
    input  logic       axiiv,
    output logic [7:0] si_axiod,
    output logic       si_axiov,
    output logic [7:0] md_axiod,
    output logic       md_axiov,
    output logic       hdr_valid,
    output logic [3:0] bitrate_index,
    output logic [1:0] sampling_freq,
    output logic       padding,
    output logic       protection_absent,
    output logic [1:0] mode,
    output logic [1:0] mode_ext,
    output len_t       frame_len,
    output logic       frame_done,
    output logic       sync_lost
);

    state_t     state, state_n;
    len_t       cnt, cnt_n;
    logic       locked, locked_n;
    logic [7:0] si_d_n, md_d_n;
    logic       si_v_n, md_v_n, hdr_v_n, done_n, lost_n;
    logic [3:0] br_n;
    logic [1:0] sf_n, mode_n, ext_n;
    logic       pad_n, pa_n;
    len_t       flen_n;
    len_t       rom_len;
    len_t       hdr_bytes, side_len, side_last, new_side;

    mp3_frame_len_rom u_rom (
        .bitrate_index (bitrate_index),
        .sampling_freq (sampling_freq),
        .padding       (padding),
        .frame_len     (rom_len)
    );

    assign hdr_bytes = protection_absent ? len_t'(HDR_LEN)
                                         : len_t'(HDR_LEN + CRC_LEN);
    assign side_len  = (mode == MODE_MONO) ? len_t'(SIDE_LEN_MONO)
                                           : len_t'(SIDE_LEN_STEREO);
    assign side_last = hdr_bytes + side_len - 1'b1;
    assign new_side  = (axiid[7:6] == MODE_MONO) ? len_t'(SIDE_LEN_MONO)
                                                 : len_t'(SIDE_LEN_STEREO);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        locked_n = locked;
        si_d_n   = si_axiod;
        md_d_n   = md_axiod;
        si_v_n   = 1'b0;
        md_v_n   = 1'b0;
        hdr_v_n  = 1'b0;
        done_n   = 1'b0;
        lost_n   = 1'b0;
        br_n     = bitrate_index;
        sf_n     = sampling_freq;
        pad_n    = padding;
        pa_n     = protection_absent;
        mode_n   = mode;
        ext_n    = mode_ext;
        flen_n   = frame_len;
        if (axiiv) begin
            cnt_n = cnt + 1'b1;
            unique case (state)
                HUNT: begin
                    cnt_n = '0;
                    if (axiid == SYNC_BYTE) begin
                        state_n = SYNC2;
                        cnt_n   = len_t'(POS_SYNC2);
                    end
                end
                SYNC2: begin
                    if (axiid[7:1] == SYNC2_PAT) begin
                        state_n = HDR3;
                        pa_n    = axiid[0];
                    end else if (axiid == SYNC_BYTE) begin
                        cnt_n = len_t'(POS_SYNC2);
                    end else begin
                        state_n  = HUNT;
                        cnt_n    = len_t'(POS_SYNC1);
                        lost_n   = locked;
                        locked_n = 1'b0;
                    end
                end
                HDR3: begin
                    if (axiid[7:4] != 4'd0 && axiid[7:4] != 4'd15 &&
                        axiid[3:2] != 2'd3) begin
                        state_n = HDR4;
                        br_n    = axiid[7:4];
                        sf_n    = axiid[3:2];
                        pad_n   = axiid[1];
                    end else begin
                        // A trailing 0xFF here is deliberately not a new sync
                        state_n  = HUNT;
                        cnt_n    = '0;
                        lost_n   = locked;
                        locked_n = 1'b0;
                    end
                end
                HDR4: begin
                    mode_n = axiid[7:6];
                    ext_n  = axiid[5:4];
                    if (rom_len <= hdr_bytes + new_side) begin
                        state_n  = HUNT;
                        cnt_n    = '0;
                        lost_n   = 1'b1;
                        locked_n = 1'b0;
                    end else begin
                        hdr_v_n = 1'b1;
                        flen_n  = rom_len;
                        state_n = protection_absent ? SIDE : CRC;
                    end
                end
                CRC: begin
                    if (cnt == len_t'(HDR_LEN + CRC_LEN - 1)) state_n = SIDE;
                end
                SIDE: begin
                    si_v_n = 1'b1;
                    si_d_n = axiid;
                    if (cnt == side_last) state_n = MAIN;
                end
                MAIN: begin
                    md_v_n = 1'b1;
                    md_d_n = axiid;
                    if (cnt == frame_len - 1'b1) begin
                        state_n = EXPECT;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end
                EXPECT: begin
                    if (axiid == SYNC_BYTE) begin
                        state_n  = SYNC2;
                        cnt_n    = len_t'(POS_SYNC2);
                        locked_n = 1'b1;
                    end else begin
                        state_n  = HUNT;
                        cnt_n    = '0;
                        lost_n   = 1'b1;
                        locked_n = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= HUNT;
            cnt               <= '0;
            locked            <= 1'b0;
            si_axiod          <= '0;
            si_axiov          <= 1'b0;
            md_axiod          <= '0;
            md_axiov          <= 1'b0;
            hdr_valid         <= 1'b0;
            bitrate_index     <= '0;
            sampling_freq     <= '0;
            padding           <= 1'b0;
            protection_absent <= 1'b0;
            mode              <= '0;
            mode_ext          <= '0;
            frame_len         <= '0;
            frame_done        <= 1'b0;
            sync_lost         <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            locked            <= locked_n;
            si_axiod          <= si_d_n;
            si_axiov          <= si_v_n;
            md_axiod          <= md_d_n;
            md_axiov          <= md_v_n;
            hdr_valid         <= hdr_v_n;
            bitrate_index     <= br_n;
            sampling_freq     <= sf_n;
            padding           <= pad_n;
            protection_absent <= pa_n;
            mode              <= mode_n;
            mode_ext          <= ext_n;
            frame_len         <= flen_n;
            frame_done        <= done_n;
            sync_lost         <= lost_n;
        end
    end

endmodule

// File: tb/tb_mp3_frame_parser.sv
// Directed bench for mp3_frame_parser: whole frames, CRC, mono, garbage,
// lost sync, gapped input and mid-frame reset.
module tb_mp3_frame_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  axiid;
    logic        axiiv;
    logic [7:0]  si_axiod;
    logic        si_axiov;
    logic [7:0]  md_axiod;
    logic        md_axiov;
    logic        hdr_valid;
    logic [3:0]  bitrate_index;
    logic [1:0]  sampling_freq;
    logic        padding;
    logic        protection_absent;
    logic [1:0]  mode;
    logic [1:0]  mode_ext;
    logic [10:0] frame_len;
    logic        frame_done;
    logic        sync_lost;

    mp3_frame_parser dut (
        .clk               (clk),
        .rst               (rst),
        .axiid             (axiid),
        .axiiv             (axiiv),
        .si_axiod          (si_axiod),
        .si_axiov          (si_axiov),
        .md_axiod          (md_axiod),
        .md_axiov          (md_axiov),
        .hdr_valid         (hdr_valid),
        .bitrate_index     (bitrate_index),
        .sampling_freq     (sampling_freq),
        .padding           (padding),
        .protection_absent (protection_absent),
        .mode              (mode),
        .mode_ext          (mode_ext),
        .frame_len         (frame_len),
        .frame_done        (frame_done),
        .sync_lost         (sync_lost)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int n_si = 0, n_md = 0, n_hdr = 0, n_done = 0, n_lost = 0;
    int md_at_done = 0;
    logic [7:0]  si_hist [0:8191];
    logic [7:0]  md_hist [0:8191];
    logic [10:0] cap_len = '0;
    logic [3:0]  cap_br = '0;
    logic [1:0]  cap_sf = '0;
    logic [1:0]  cap_mode = '0;
    logic [1:0]  cap_ext = '0;
    logic        cap_pa = 1'b0;

    int b_si, b_md, b_hdr, b_done, b_lost;

    always @(negedge clk) begin
        if (si_axiov) begin
            if (n_si < 8192) si_hist[n_si[12:0]] <= si_axiod;
            n_si <= n_si + 1;
        end
        if (md_axiov) begin
            if (n_md < 8192) md_hist[n_md[12:0]] <= md_axiod;
            n_md <= n_md + 1;
        end
        if (hdr_valid) begin
            n_hdr    <= n_hdr + 1;
            cap_len  <= frame_len;
            cap_br   <= bitrate_index;
            cap_sf   <= sampling_freq;
            cap_mode <= mode;
            cap_ext  <= mode_ext;
            cap_pa   <= protection_absent;
        end
        if (frame_done) begin
            n_done     <= n_done + 1;
            md_at_done <= n_md + (md_axiov ? 1 : 0);
        end
        if (sync_lost) n_lost <= n_lost + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int k);
        logic [7:0] b;
        b = 8'(k);
        return b & 8'h7F;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        axiid = b;
        axiiv = 1'b1;
        @(posedge clk);
        #1;
        axiiv = 1'b0;
        idle(gap);
    endtask

    task automatic frame(input logic [7:0] h1, input logic [7:0] h2,
                         input logic [7:0] h3, input int len,
                         input int gap);
        put(8'hFF, gap);
        put(h1, gap);
        put(h2, gap);
        put(h3, gap);
        for (int k = 0; k < len - 4; k++) put(pay(k), gap);
    endtask

    task automatic snap();
        b_si   = n_si;
        b_md   = n_md;
        b_hdr  = n_hdr;
        b_done = n_done;
        b_lost = n_lost;
    endtask

    task automatic deltas(input string tag, input int si, input int md,
                          input int hdr, input int done, input int lost);
        check({tag, ".si"},   64'(n_si - b_si),     64'(si));
        check({tag, ".md"},   64'(n_md - b_md),     64'(md));
        check({tag, ".hdr"},  64'(n_hdr - b_hdr),   64'(hdr));
        check({tag, ".done"}, 64'(n_done - b_done), 64'(done));
        check({tag, ".lost"}, 64'(n_lost - b_lost), 64'(lost));
    endtask

    task automatic all_zero(input string tag);
        check(tag, {si_axiod, si_axiov, md_axiod, md_axiov, hdr_valid,
                    bitrate_index, sampling_freq, padding,
                    protection_absent, mode, mode_ext, frame_len,
                    frame_done, sync_lost}, 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        axiid = 8'h00;
        axiiv = 1'b0;
        idle(3);
        all_zero("reset_outputs");
        rst = 1'b0;
        idle(1);

        // 128k / 44.1k, no CRC, joint stereo
        snap();
        put(8'h00, 0);
        frame(8'hFB, 8'h90, 8'h64, 417, 0);
        idle(2);
        deltas("stereo", 32, 381, 1, 1, 0);
        check("stereo.frame_len", 64'(cap_len), 64'd417);
        check("stereo.br", 64'(cap_br), 64'd9);
        check("stereo.sf", 64'(cap_sf), 64'd0);
        check("stereo.mode", 64'(cap_mode), 64'd1);
        check("stereo.ext", 64'(cap_ext), 64'd2);
        check("stereo.prot_abs", 64'(cap_pa), 64'd1);
        check("stereo.md_at_done", 64'(md_at_done - b_md), 64'd381);
        check("stereo.first_si", 64'(si_hist[b_si]), 64'h00);
        check("stereo.last_md", 64'(md_hist[n_md - 1]), 64'h1C);

        // Same header with CRC present
        snap();
        frame(8'hFA, 8'h90, 8'h64, 417, 0);
        idle(2);
        deltas("crc", 32, 379, 1, 1, 0);
        check("crc.prot_abs", 64'(cap_pa), 64'd0);
        check("crc.first_si", 64'(si_hist[b_si]), 64'h02);
        check("crc.last_md", 64'(md_hist[n_md - 1]), 64'h1C);

        // 128k / 48k mono
        snap();
        frame(8'hFB, 8'h94, 8'hC4, 384, 0);
        idle(2);
        deltas("mono", 17, 363, 1, 1, 0);
        check("mono.frame_len", 64'(cap_len), 64'd384);
        check("mono.mode", 64'(cap_mode), 64'd3);
        check("mono.md_at_done", 64'(md_at_done - b_md), 64'd363);
        check("mono.last_md", 64'(md_hist[n_md - 1]), 64'h7B);

        // Break lock, then garbage with bitrate 15 must not lock
        snap();
        put(8'h00, 0);
        put(8'hFF, 0);
        put(8'hFF, 0);
        put(8'hFF, 0);
        put(8'hFB, 0);
        put(8'hF0, 0);
        put(8'h12, 0);
        put(8'h34, 0);
        idle(2);
        deltas("garbage", 0, 0, 0, 0, 1);

        snap();
        frame(8'hFB, 8'h90, 8'h64, 417, 0);
        idle(2);
        deltas("relock", 32, 381, 1, 1, 0);

        // Back-to-back with the second sync byte corrupted
        snap();
        frame(8'hFB, 8'h90, 8'h64, 417, 0);
        put(8'hFF, 0);
        put(8'h00, 0);
        for (int k = 0; k < 411; k++) put(pay(k), 0);
        idle(2);
        deltas("b2b", 32, 381, 1, 1, 1);

        // Valid header after lost sync, input gapped every other cycle
        snap();
        frame(8'hFB, 8'h90, 8'h64, 417, 1);
        idle(2);
        deltas("gapped", 32, 381, 1, 1, 0);
        check("gapped.frame_len", 64'(cap_len), 64'd417);
        check("gapped.md_at_done", 64'(md_at_done - b_md), 64'd381);

        // Reset after ten side-info bytes
        snap();
        put(8'hFF, 0);
        put(8'hFB, 0);
        put(8'h90, 0);
        put(8'h64, 0);
        for (int k = 0; k < 10; k++) put(pay(k), 0);
        idle(1);
        deltas("partial", 10, 0, 1, 0, 0);
        rst = 1'b1;
        idle(2);
        all_zero("midreset_outputs");
        rst = 1'b0;
        snap();
        for (int k = 10; k < 413; k++) put(pay(k), 0);
        idle(2);
        deltas("after_reset", 0, 0, 0, 0, 0);

        snap();
        frame(8'hFB, 8'h90, 8'h64, 417, 0);
        idle(2);
        deltas("post_reset", 32, 381, 1, 1, 0);
        check("post_reset.frame_len", 64'(cap_len), 64'd417);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp3_frame_parser.md
Name: mp3_frame_parser

Overview:
- Byte-stream front end of the MPEG-1 Layer III decoder.
- Hunts for frame sync and validates and registers the 4-byte frame header, then discards the optional 16-bit CRC.
- Routes the side-info bytes to the side-info parser stage and the remaining frame payload (main data) to the bit-reservoir stage.
- Tracks frame length so that it re-checks sync at every frame boundary.

Parameters:
- MAX_FRAME_BYTES, 1441, largest legal frame in bytes (320 kbps, 32 kHz, padded); sets byte-counter width to 11 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- axiid  in  8  incoming MP3 byte stream
- axiiv  in  1  axiid valid; no backpressure, one byte per asserted cycle
- si_axiod  out  8  side-info byte
- si_axiov  out  1  si_axiod valid
- md_axiod  out  8  main-data byte
- md_axiov  out  1  md_axiod valid
- hdr_valid  out  1  one-cycle pulse when header fields below are updated
- bitrate_index  out  4  header bits 15:12 of byte 2
- sampling_freq  out  2  header
- padding  out  1  header
- protection_absent  out  1  header (1 = no CRC)
- mode  out  2  channel mode (3 = mono)
- mode_ext  out  2  mode extension
- frame_len  out  11  total frame bytes incl. header, from table
- frame_done  out  1  pulse on last byte of a frame
- sync_lost  out  1  pulse when expected header at frame boundary fails validation

Behaviour:
- Reset: state = HUNT; byte counter = 0; all outputs = 0.
- Inputs are consumed only on axiiv=1. State holds when axiiv=0. Output valids are 0 on any cycle that did not register an accepted byte.
- Outputs are registered with 1-cycle latency: a byte accepted in cycle n appears on si_/md_ outputs in cycle n+1.
- States and transitions:
  - HUNT: byte==8'hFF -> SYNC2.
  - SYNC2: byte[7:1]==7'b1111101 (sync, ID=1, layer III) -> HDR3, latch protection_absent=byte[0]. Else if byte==FF stay SYNC2. Else -> HUNT.
  - HDR3: bitrate_index in 1..14 and sampling_freq!=3 -> HDR4, latch bitrate_index/sampling_freq/padding. Else -> HUNT; a leftover 0xFF byte is not re-examined as sync.
  - HDR4: latch mode/mode_ext; pulse hdr_valid the next cycle with frame_len valid. -> CRC if protection_absent=0, else SIDE.
  - CRC: drop 2 bytes -> SIDE.
  - SIDE: forward exactly 32 bytes (17 if mode==3) on si_ -> MAIN.
  - MAIN: forward on md_ until byte count reaches frame_len, pulse frame_done with the last byte -> EXPECT.
  - EXPECT: byte==FF -> SYNC2 as locked. Else pulse sync_lost -> HUNT.
  - A header failing validation in SYNC2/HDR3 while locked also pulses sync_lost.
- frame_len = floor(144000*kbps/fs_Hz) + padding, read from a 14x3 constant ROM. Examples: 128 kbps/44.1 kHz = 417; 128/48 = 384; 320/32 = 1440.
- Main-data count = frame_len - 4 - (CRC ? 2 : 0) - side_len.
  - A computed count <= 0 (malformed) -> pulse sync_lost, HUNT, no md_ output.
- The byte counter counts from the first FF of the frame (0) and is compared against frame_len-1. Width is 11 bits; no wrap within a legal frame.
- Reset asserted mid-frame aborts immediately. No partial-frame flush.
- No bytes are emitted on si_/md_ outside SIDE/MAIN.

Decomposition:
- Package mp3_pkg:
  - state enum.
  - header byte-position constants.
  - SIDE_LEN_STEREO=32, SIDE_LEN_MONO=17, CRC_LEN=2, HDR_LEN=4.
  - Frame-length ROM as a constant array indexed [bitrate_index][sampling_freq] for padding=0.
- One sub-module: mp3_frame_len_rom (combinational lookup + padding add).

Test Plan:
- Reset, then feed 00 FF FB 90 64 (128k/44.1k, no CRC, joint stereo) + 413 payload bytes -> hdr_valid pulse, frame_len=417, 32 si_axiov beats, 381 md_axiov beats, frame_done on byte 417.
- Same header with byte2=FA (CRC) -> 2 bytes dropped; 32 si beats, 379 md beats.
- Mono header FF FB 94 C4 (128k/48k, mode 3) -> frame_len=384, 17 si beats, 363 md beats.
- Garbage FF FF FF FB F0 .. (bitrate 15) -> stays unlocked, no si/md valids; a following valid header locks normally.
- Two back-to-back frames with a corrupted second sync byte (00) -> sync_lost pulse at the boundary, no further output until the next valid header.
- axiiv toggled every other cycle through a whole frame, and rst asserted at side-info byte 10 -> counts identical to the gapless case; after reset all outputs 0 and state HUNT.
